// File: rtl/wt_store_wbuf_pkg.sv
// Shared types and sizing for the write-through store write buffer.
//
// Entry states:
//   state | meaning
//   FREE  | slot unused
//   PEND  | buffered, not yet issued; may absorb later stores to its word
//   SENT  | issued to memory, held until its completion ack arrives
//
// The entry record is sized from the core configuration below
// (XLEN 32, depth 8, TID width 2).
package wt_store_wbuf_pkg;

  localparam int WBUF_XLEN  = 32;
  localparam int WBUF_DEPTH = 8;
  localparam int WBUF_TID_W = 2;
  localparam int WBUF_BE_W  = WBUF_XLEN / 8;
  localparam int WBUF_AW    = WBUF_XLEN - $clog2(WBUF_BE_W);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    PEND = 2'd1,
    SENT = 2'd2
  } wbuf_state_e;

  typedef struct packed {
    logic [WBUF_AW-1:0]    addr;   // word address
    logic [WBUF_XLEN-1:0]  data;
    logic [WBUF_BE_W-1:0]  be;
    logic [WBUF_TID_W-1:0] tid;
    wbuf_state_e           state;
  } wbuf_entry_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int wbuf_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wt_store_wbuf_if.sv
// Bus bundle for wt_store_wbuf.
//   store request : req_valid_i, req_ready_o, req_addr_i, req_data_i, req_be_i
//   memory write  : mem_valid_o, mem_ready_i, mem_addr_o, mem_data_o,
//                   mem_be_o, mem_tid_o, mem_ack_i, mem_ack_tid_i
//   load forward  : rd_addr_i, rd_hit_o, rd_data_o, rd_be_o
//   status        : empty_o, full_o
// Modports: slave = the buffer itself, master = LSU/memory side driving it.
interface wt_store_wbuf_if #(
  parameter int XLEN  = 32,
  parameter int TID_W = 2
);
  localparam int BE_W = XLEN / 8;

  logic             req_valid_i;
  logic             req_ready_o;
  logic [XLEN-1:0]  req_addr_i;
  logic [XLEN-1:0]  req_data_i;
  logic [BE_W-1:0]  req_be_i;

  logic             mem_valid_o;
  logic             mem_ready_i;
  logic [XLEN-1:0]  mem_addr_o;
  logic [XLEN-1:0]  mem_data_o;
  logic [BE_W-1:0]  mem_be_o;
  logic [TID_W-1:0] mem_tid_o;
  logic             mem_ack_i;
  logic [TID_W-1:0] mem_ack_tid_i;

  logic [XLEN-1:0]  rd_addr_i;
  logic             rd_hit_o;
  logic [XLEN-1:0]  rd_data_o;
  logic [BE_W-1:0]  rd_be_o;

  logic             empty_o;
  logic             full_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_be_i,
    output req_ready_o,
    output mem_valid_o, mem_addr_o, mem_data_o, mem_be_o, mem_tid_o,
    input  mem_ready_i, mem_ack_i, mem_ack_tid_i,
    input  rd_addr_i,
    output rd_hit_o, rd_data_o, rd_be_o,
    output empty_o, full_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_be_i,
    input  req_ready_o,
    input  mem_valid_o, mem_addr_o, mem_data_o, mem_be_o, mem_tid_o,
    output mem_ready_i, mem_ack_i, mem_ack_tid_i,
    output rd_addr_i,
    input  rd_hit_o, rd_data_o, rd_be_o,
    input  empty_o, full_o
  );

endinterface

// File: rtl/wt_store_wbuf_lookup.sv
// Youngest-first word-address match across the buffer slots.
//   cand_i : per-slot enable (which slots may match)
//   addr_i : per-slot word address
//   key_i  : word address searched for
//   tail_i : slot index of the next free slot (defines age order)
//   hit_o  : some enabled slot matches
//   idx_o  : youngest matching slot
module wt_store_wbuf_lookup #(
  parameter int DEPTH = 8,
  parameter int AW    = 30,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]         cand_i,
  input  logic [DEPTH-1:0][AW-1:0] addr_i,
  input  logic [AW-1:0]            key_i,
  input  logic [IW-1:0]            tail_i,
  output logic                     hit_o,
  output logic [IW-1:0]            idx_o
);

  // Walk from tail (oldest) towards tail-1 (youngest); later hits overwrite.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (cand_i[tail_i + IW'(k)] && (addr_i[tail_i + IW'(k)] == key_i)) begin
        hit_o = 1'b1;
        idx_o = tail_i + IW'(k);
      end
    end
  end

endmodule

// File: rtl/wt_store_wbuf.sv
// Merging write buffer between the LSU store path and the write-through
// data-cache memory port. Stores coalesce into un-issued entries of the same
// word, entries drain oldest-first with a wrapping transaction ID, and acks
// retire entries in issue order.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset; drops every entry
//   bus    : wt_store_wbuf_if.slave (store request, memory write, forwarding,
//            empty/full status)
// Build option: define WT_STORE_WBUF_FWD_EN to build load forwarding;
// otherwise rd_hit_o/rd_data_o/rd_be_o are tied to zero.
module wt_store_wbuf
  import wt_store_wbuf_pkg::*;
#(
  parameter int XLEN  = WBUF_XLEN,
  parameter int DEPTH = WBUF_DEPTH,
  parameter int TID_W = WBUF_TID_W
) (
  input logic            clk_i,
  input logic            rst_ni,
  wt_store_wbuf_if.slave bus
);

  localparam int BE_W  = XLEN / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int AW    = XLEN - OFF_W;
  localparam int IW    = $clog2(DEPTH);
  localparam int PW    = wbuf_ptr_w(DEPTH);
  localparam logic [PW:0] MAX_OUT = (PW+1)'(1 << TID_W);

  wbuf_entry_t ent [DEPTH];
  logic [PW-1:0]    head, iss, tail;
  logic [TID_W-1:0] tid_cnt;
  logic             ever_issued;

  logic [IW-1:0] head_idx, iss_idx, tail_idx;
  logic [PW-1:0] n_out;
  logic          full, empty, mem_valid;

  assign head_idx = head[IW-1:0];
  assign iss_idx  = iss[IW-1:0];
  assign tail_idx = tail[IW-1:0];
  assign n_out    = iss - head;
  assign empty    = (head == tail);
  assign full     = (head_idx == tail_idx) && (head[PW-1] != tail[PW-1]);
  assign mem_valid = (iss != tail) && ({1'b0, n_out} < MAX_OUT);

  logic [DEPTH-1:0][AW-1:0] ent_addr;
  logic [DEPTH-1:0]         merge_cand, live;

  // The entry on mem_valid_o must stay stable, so it is never a merge target.
  always_comb begin
    ent_addr   = '0;
    merge_cand = '0;
    live       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_addr[i]   = ent[i].addr;
      merge_cand[i] = (ent[i].state == PEND) && !(mem_valid && (iss_idx == IW'(i)));
      live[i]       = (ent[i].state != FREE);
    end
  end

  logic          merge_hit;
  logic [IW-1:0] merge_idx;

  wt_store_wbuf_lookup #(.DEPTH(DEPTH), .AW(AW)) u_merge (
    .cand_i (merge_cand),
    .addr_i (ent_addr),
    .key_i  (bus.req_addr_i[XLEN-1:OFF_W]),
    .tail_i (tail_idx),
    .hit_o  (merge_hit),
    .idx_o  (merge_idx)
  );

  logic            req_ready, accept, do_merge, do_alloc, do_issue, do_ack;
  logic [XLEN-1:0] merged_data;

  assign req_ready = merge_hit || !full;
  assign accept    = bus.req_valid_i && req_ready;
  assign do_merge  = accept && merge_hit && (|bus.req_be_i);
  assign do_alloc  = accept && !merge_hit && (|bus.req_be_i);
  assign do_issue  = mem_valid && bus.mem_ready_i;
  // head == iss means nothing is outstanding; such acks (e.g. stale ones
  // from before a reset) are dropped.
  assign do_ack    = bus.mem_ack_i && (head != iss);

  always_comb begin
    merged_data = ent[merge_idx].data;
    for (int b = 0; b < BE_W; b++) begin
      if (bus.req_be_i[b]) merged_data[8*b +: 8] = bus.req_data_i[8*b +: 8];
    end
  end

  // Ack, issue, merge and allocate always target distinct slots.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      head        <= '0;
      iss         <= '0;
      tail        <= '0;
      tid_cnt     <= '0;
      ever_issued <= 1'b0;
    end else begin
      if (do_ack) begin
        ent[head_idx].state <= FREE;
        head <= head + PW'(1);
      end
      if (do_issue) begin
        ent[iss_idx].state <= SENT;
        ent[iss_idx].tid   <= tid_cnt;
        iss         <= iss + PW'(1);
        tid_cnt     <= tid_cnt + TID_W'(1);
        ever_issued <= 1'b1;
      end
      if (do_merge) begin
        ent[merge_idx].data <= merged_data;
        ent[merge_idx].be   <= ent[merge_idx].be | bus.req_be_i;
      end
      if (do_alloc) begin
        ent[tail_idx] <= '{addr:  bus.req_addr_i[XLEN-1:OFF_W],
                           data:  bus.req_data_i,
                           be:    bus.req_be_i,
                           tid:   '0,
                           state: PEND};
        tail <= tail + PW'(1);
      end
    end
  end

  assign bus.req_ready_o = req_ready;
  assign bus.mem_valid_o = mem_valid;
  assign bus.mem_addr_o  = {ent[iss_idx].addr, {OFF_W{1'b0}}};
  assign bus.mem_data_o  = ent[iss_idx].data;
  assign bus.mem_be_o    = ent[iss_idx].be;
  assign bus.mem_tid_o   = tid_cnt;
  assign bus.empty_o     = empty;
  assign bus.full_o      = full;

`ifdef WT_STORE_WBUF_FWD_EN
  logic          fwd_hit;
  logic [IW-1:0] fwd_idx;

  wt_store_wbuf_lookup #(.DEPTH(DEPTH), .AW(AW)) u_fwd (
    .cand_i (live),
    .addr_i (ent_addr),
    .key_i  (bus.rd_addr_i[XLEN-1:OFF_W]),
    .tail_i (tail_idx),
    .hit_o  (fwd_hit),
    .idx_o  (fwd_idx)
  );

  assign bus.rd_hit_o  = fwd_hit;
  assign bus.rd_data_o = fwd_hit ? ent[fwd_idx].data : '0;
  assign bus.rd_be_o   = fwd_hit ? ent[fwd_idx].be : '0;

  logic unused_lsb;
  assign unused_lsb = ^{bus.req_addr_i[OFF_W-1:0], bus.rd_addr_i[OFF_W-1:0]};
`else
  assign bus.rd_hit_o  = 1'b0;
  assign bus.rd_data_o = '0;
  assign bus.rd_be_o   = '0;

  logic unused_rd;
  assign unused_rd = ^{bus.req_addr_i[OFF_W-1:0], bus.rd_addr_i, live};
`endif

  // Acks must retire an outstanding entry, and carry that entry's TID.
  // Acks before the first issue after reset may be stale and are ignored.
  a_ack_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.mem_ack_i && ever_issued) |-> (head != iss));
  a_ack_tid: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.mem_ack_i && (head != iss)) |-> (bus.mem_ack_tid_i == ent[head_idx].tid));

endmodule

// File: tb/tb_wt_store_wbuf.sv
module tb_wt_store_wbuf;

`ifdef WT_STORE_WBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  wt_store_wbuf_if #(.XLEN(32), .TID_W(2)) bus ();

  wt_store_wbuf #(.XLEN(32), .DEPTH(8), .TID_W(2)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic        mr;
    logic        ack;
    logic [1:0]  atid;
    logic        e_rdy;
    logic        e_mv;
    logic [31:0] e_maddr;
    logic [31:0] e_mdata;
    logic [3:0]  e_mbe;
    logic [1:0]  e_mtid;
    logic        e_full;
    logic        e_empty;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic v, logic [31:0] addr, logic [31:0] data, logic [3:0] be,
                              logic mr, logic ack, logic [1:0] atid,
                              logic e_rdy, logic e_mv, logic [31:0] e_maddr, logic [31:0] e_mdata,
                              logic [3:0] e_mbe, logic [1:0] e_mtid, logic e_full, logic e_empty);
    vec_t r;
    r.v = v; r.addr = addr; r.data = data; r.be = be;
    r.mr = mr; r.ack = ack; r.atid = atid;
    r.e_rdy = e_rdy; r.e_mv = e_mv; r.e_maddr = e_maddr; r.e_mdata = e_mdata;
    r.e_mbe = e_mbe; r.e_mtid = e_mtid; r.e_full = e_full; r.e_empty = e_empty;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic mr, input logic ack,
                       input logic [1:0] atid);
    bus.req_valid_i   = v;
    bus.req_addr_i    = a;
    bus.req_data_i    = d;
    bus.req_be_i      = be;
    bus.mem_ready_i   = mr;
    bus.mem_ack_i     = ack;
    bus.mem_ack_tid_i = atid;
  endtask

  // Advance to the next negedge, apply inputs, settle before sampling.
  task automatic cyc(input logic v, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be, input logic mr, input logic ack,
                     input logic [1:0] atid);
    @(negedge clk_i);
    drive(v, a, d, be, mr, ack, atid);
    #1;
  endtask

  task automatic chk_mem(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input logic [1:0] tid);
    chk({tag, ".mem_valid"}, 32'(bus.mem_valid_o), 32'd1);
    chk({tag, ".mem_addr"},  bus.mem_addr_o, a);
    chk({tag, ".mem_data"},  bus.mem_data_o, d);
    chk({tag, ".mem_be"},    32'(bus.mem_be_o), 32'(be));
    chk({tag, ".mem_tid"},   32'(bus.mem_tid_o), 32'(tid));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_i);
    rst_ni = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    bus.rd_addr_i = 32'h0;
    #1;
    chk({tag, ".mem_valid"}, 32'(bus.mem_valid_o), 32'd0);
    chk({tag, ".empty"},     32'(bus.empty_o), 32'd1);
    chk({tag, ".full"},      32'(bus.full_o), 32'd0);
    chk({tag, ".req_ready"}, 32'(bus.req_ready_o), 32'd1);
    chk({tag, ".rd_hit"},    32'(bus.rd_hit_o), 32'd0);
    chk({tag, ".rd_data"},   bus.rd_data_o, 32'd0);
    chk({tag, ".rd_be"},     32'(bus.rd_be_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 2'd0);
    bus.rd_addr_i = 32'h0;

    // Merge behind a presented entry, fill to full, drain against the TID limit.
    vecs.push_back(mk(0, 32'h0,    32'h0,        4'h0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 32'h1000, 32'h0000AAAA, 4'h3, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1002, 32'hBBBB0000, 4'hC, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1001, 32'h12345678, 4'h0, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1100, 32'h11001100, 4'hF, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1104, 32'h33333300, 4'hE, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1108, 32'h11081108, 4'hF, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h110C, 32'h110C110C, 4'hF, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1110, 32'h11101110, 4'hF, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h1114, 32'h11141114, 4'hF, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 0, 0));
    vecs.push_back(mk(1, 32'h5000, 32'h55555555, 4'hF, 0, 0, 0, 0, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 1, 0));
    vecs.push_back(mk(1, 32'h1104, 32'h000000EE, 4'h1, 0, 0, 0, 1, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 1, 0));
    vecs.push_back(mk(1, 32'h0F00, 32'hFFFFFFFF, 4'h1, 0, 0, 0, 0, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,    32'h0,        4'h0, 1, 0, 0, 0, 1, 32'h0F00, 32'h0F0F0F0F, 4'hF, 0, 1, 0));
    vecs.push_back(mk(0, 32'h0,    32'h0,        4'h0, 1, 0, 0, 0, 1, 32'h1000, 32'hBBBBAAAA, 4'hF, 1, 1, 0));
    vecs.push_back(mk(0, 32'h0,    32'h0,        4'h0, 1, 0, 0, 0, 1, 32'h1100, 32'h11001100, 4'hF, 2, 1, 0));
    vecs.push_back(mk(0, 32'h0,    32'h0,        4'h0, 1, 0, 0, 0, 1, 32'h1104, 32'h333333EE, 4'hF, 3, 1, 0));
    vecs.push_back(mk(0, 32'h0,    32'h0,        4'h0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 32'h6000, 32'h66666666, 4'hF, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 32'h6000, 32'h66666666, 4'hF, 1, 0, 0, 1, 1, 32'h1108, 32'h11081108, 4'hF, 0, 0, 0));
    vecs.push_back(mk(0, 32'h0,    32'h0,        4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));

    do_reset("rst0");

    foreach (vecs[i]) begin
      cyc(vecs[i].v, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].mr, vecs[i].ack, vecs[i].atid);
      chk($sformatf("v%0d.req_ready", i), 32'(bus.req_ready_o), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d.mem_valid", i), 32'(bus.mem_valid_o), 32'(vecs[i].e_mv));
      chk($sformatf("v%0d.full", i),      32'(bus.full_o), 32'(vecs[i].e_full));
      chk($sformatf("v%0d.empty", i),     32'(bus.empty_o), 32'(vecs[i].e_empty));
      if (vecs[i].e_mv) begin
        chk($sformatf("v%0d.mem_addr", i), bus.mem_addr_o, vecs[i].e_maddr);
        chk($sformatf("v%0d.mem_data", i), bus.mem_data_o, vecs[i].e_mdata);
        chk($sformatf("v%0d.mem_be", i),   32'(bus.mem_be_o), 32'(vecs[i].e_mbe));
        chk($sformatf("v%0d.mem_tid", i),  32'(bus.mem_tid_o), 32'(vecs[i].e_mtid));
      end
    end

    // Store to the word being issued in the same cycle allocates a new entry.
    do_reset("rst1");
    cyc(1, 32'h2000, 32'h20202020, 4'hF, 0, 0, 0);
    chk("iss_same.ready0", 32'(bus.req_ready_o), 32'd1);
    cyc(1, 32'h2000, 32'h000000AB, 4'h1, 1, 0, 0);
    chk("iss_same.ready1", 32'(bus.req_ready_o), 32'd1);
    chk_mem("iss_same.first", 32'h2000, 32'h20202020, 4'hF, 2'd0);
    cyc(0, 32'h0, 32'h0, 4'h0, 1, 0, 0);
    chk_mem("iss_same.second", 32'h2000, 32'h000000AB, 4'h1, 2'd1);
    cyc(0, 32'h0, 32'h0, 4'h0, 0, 1, 2'd0);
    chk("iss_same.drained", 32'(bus.mem_valid_o), 32'd0);
    cyc(0, 32'h0, 32'h0, 4'h0, 0, 1, 2'd1);
    chk("iss_same.not_empty", 32'(bus.empty_o), 32'd0);
    cyc(0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    chk("iss_same.empty", 32'(bus.empty_o), 32'd1);

    // Forwarding: SENT and PEND copies of one word, youngest wins.
    do_reset("rst2");
    cyc(1, 32'h3000, 32'h11111111, 4'hF, 0, 0, 0);
    cyc(0, 32'h0, 32'h0, 4'h0, 1, 0, 0);
    chk("fwd.issue_valid", 32'(bus.mem_valid_o), 32'd1);
    cyc(1, 32'h3000, 32'h00000022, 4'h1, 0, 0, 0);
    chk("fwd.alloc_ready", 32'(bus.req_ready_o), 32'd1);
    cyc(0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    bus.rd_addr_i = 32'h3001;
    #1;
    chk_mem("fwd.pend", 32'h3000, 32'h00000022, 4'h1, 2'd1);
    chk("fwd.hit",  32'(bus.rd_hit_o), FWD ? 32'd1 : 32'd0);
    chk("fwd.data", bus.rd_data_o, FWD ? 32'h22 : 32'h0);
    chk("fwd.be",   32'(bus.rd_be_o), FWD ? 32'h1 : 32'h0);
    bus.rd_addr_i = 32'h3004;
    #1;
    chk("fwd.miss_hit",  32'(bus.rd_hit_o), 32'd0);
    chk("fwd.miss_data", bus.rd_data_o, 32'd0);
    cyc(1, 32'h3008, 32'h88888888, 4'hF, 1, 0, 0);
    cyc(0, 32'h0, 32'h0, 4'h0, 1, 0, 0);
    chk_mem("fwd.third", 32'h3008, 32'h88888888, 4'hF, 2'd2);
    cyc(0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    bus.rd_addr_i = 32'h3000;
    #1;
    chk("fwd.sent_idle", 32'(bus.mem_valid_o), 32'd0);
    chk("fwd.sent_hit",  32'(bus.rd_hit_o), FWD ? 32'd1 : 32'd0);
    chk("fwd.sent_data", bus.rd_data_o, FWD ? 32'h22 : 32'h0);

    // Reset with three SENT entries; a late ack must be ignored.
    do_reset("rst3");
    cyc(0, 32'h0, 32'h0, 4'h0, 0, 1, 2'd0);
    chk("stale.empty", 32'(bus.empty_o), 32'd1);
    chk("stale.mem_valid", 32'(bus.mem_valid_o), 32'd0);
    cyc(0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
    chk("stale.empty_after", 32'(bus.empty_o), 32'd1);
    chk("stale.full_after", 32'(bus.full_o), 32'd0);
    chk("stale.valid_after", 32'(bus.mem_valid_o), 32'd0);
    cyc(1, 32'h4000, 32'h44444444, 4'hF, 0, 0, 0);
    chk("stale.ready", 32'(bus.req_ready_o), 32'd1);
    cyc(0, 32'h0, 32'h0, 4'h0, 1, 0, 0);
    chk_mem("stale.restart", 32'h4000, 32'h44444444, 4'hF, 2'd0);
    cyc(0, 32'h0, 32'h0, 4'h0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wt_store_wbuf.md
# wt_store_wbuf

Merging write buffer between the load/store unit's store path and the write-through data-cache memory port. Accepts word-aligned stores and coalesces byte enables into not-yet-issued entries to the same word. Drains entries oldest-first to memory with a transaction ID. Optionally forwards buffered data to loads. Sized from the core configuration: XLEN 32, write-buffer depth 8, memory TID width 2.

## Interface
- `XLEN`, 32, data/address width
- `DEPTH`, 8, number of entries; power of two, ≥2
- `TID_W`, 2, memory transaction-ID width; max outstanding = 2^TID_W
- `clk_i`  in  1  clock
- `rst_ni`  in  1  reset. Asynchronous, active-low.
- `req_valid_i`  in  1  store request
- `req_ready_o`  out  1  store accepted when high with valid
- `req_addr_i`  in  XLEN  byte address; low log2(XLEN/8) bits ignored
- `req_data_i`  in  XLEN  store data
- `req_be_i`  in  XLEN/8  byte enables; all-zero is legal and is a no-op accept
- `mem_valid_o`  out  1  write request to memory
- `mem_ready_i`  in  1  memory accepts request
- `mem_addr_o`  out  XLEN  word-aligned address
- `mem_data_o`  out  XLEN  write data
- `mem_be_o`  out  XLEN/8  byte enables
- `mem_tid_o`  out  TID_W  transaction ID
- `mem_ack_i`  in  1  write completion
- `mem_ack_tid_i`  in  TID_W  completion ID
- `rd_addr_i`  in  XLEN  load address for forwarding
- `rd_hit_o`  out  1  some entry matches the load word
- `rd_data_o`  out  XLEN  youngest matching entry data
- `rd_be_o`  out  XLEN/8  youngest matching entry byte enables
- `empty_o`  out  1  no entries in use
- `full_o`  out  1  all DEPTH entries in use

## Operation
- Storage is a circular buffer with three pointers, each log2(DEPTH)+1 bits:
  - `head`: oldest entry, waiting for an ack.
  - `iss`: next entry to issue.
  - `tail`: next free slot.
- Entry states: FREE, PEND (buffered, mergeable), SENT (issued, waiting for ack).
- Accept:
  - Merge when the word address matches a PEND entry that is not currently presented on `mem_valid_o`. Merged data is per-byte: new bytes overwrite old, and the entry's BE becomes old BE OR new BE.
  - Otherwise allocate at `tail`, provided the buffer is not full.
  - At most one PEND entry exists per word address.
- `req_ready_o` = merge-hit OR not full. It is combinational from `req_addr_i`.
- Issue: `mem_valid_o` is high when `iss != tail` AND outstanding count < 2^TID_W.
  - `mem_tid_o` is a TID_W-bit issue counter that wraps.
  - On `mem_ready_i`, the entry goes PEND→SENT, `iss` increments and the counter increments.
- Ack: acks arrive in issue order. `mem_ack_i` frees the entry at `head` and increments `head`.
  - `mem_ack_tid_i` must equal the head entry's TID; a mismatch is an assertion failure.
  - An ack with `head == iss` is an assertion failure.
- Forwarding:
  - Match = word-address compare across PEND and SENT entries.
  - On multiple matches, the youngest (closest to `tail`) wins.
  - Only state registered before the current cycle is visible.
- Simultaneous events:
  - Accept, issue and ack in one cycle all take effect.
  - A store matching the entry being issued this cycle allocates a new entry and does not merge.
  - Full with an ack in the same cycle: `req_ready_o` stays low for a non-merging store; the freed slot is usable next cycle.
- Reset mid-operation drops all entries, including SENT entries. Acks arriving after reset are ignored.

## Timing
- Reset values: all entries FREE, pointers 0, TID counter 0, outstanding count 0.
- Outputs after reset: `mem_valid_o`=0, `empty_o`=1, `full_o`=0, `rd_hit_o`=0, `rd_data_o`=0, `rd_be_o`=0, `req_ready_o`=1.
- A store accepted in cycle N is visible on `mem_valid_o` at N+1 at the earliest.
- `mem_valid_o` and `mem_*` remain stable from assertion until `mem_ready_i`.
- `full_o` and `empty_o` are registered-state derived and update the cycle after the event.
- Forwarding is zero-cycle combinational from `rd_addr_i`.

## Configuration
- `WT_STORE_WBUF_FWD_EN` defined: the forwarding comparators and youngest-match selection are built.
- Undefined: `rd_hit_o`, `rd_data_o` and `rd_be_o` are tied to 0 and `rd_addr_i` is unused. All other behaviour is identical.

## Structure
- Package `wt_store_wbuf_pkg` holds:
  - `wbuf_state_e` (FREE/PEND/SENT)
  - `wbuf_entry_t` (word address, data, BE, TID, state)
  - the helper that derives pointer width from DEPTH
- Sub-module `wt_store_wbuf_lookup`: a parameterized youngest-first address match, reused for the merge search (PEND only) and for forwarding (PEND+SENT).

## Test plan
- Store 0x1000/BE 0x3/data 0xAAAA, then 0x1002/BE 0xC/data 0xBBBB0000 with `mem_ready_i`=0 → one entry; on issue `mem_be_o`=0xF, `mem_data_o`=0xBBBBAAAA.
- 8 stores to distinct words with `mem_ready_i`=0 → `full_o`=1 and `req_ready_o`=0 for a new address, but 1 for a store to one of the 8 buffered words.
- `mem_ready_i`=1 and acks withheld → exactly 4 issues with TIDs 0,1,2,3, then `mem_valid_o` drops; one ack (TID 0) → the fifth entry issues with TID 0.
- Store 0x2000 is being presented and accepted while a new store to 0x2000/BE 0x1 arrives in the same cycle → two entries; the second issues with BE 0x1.
- With FWD_EN: buffer 0x3000=0x11111111 (SENT) and 0x3000=0x22 BE 0x1 (PEND), set `rd_addr_i`=0x3001 → `rd_hit_o`=1, `rd_data_o`=0x22, `rd_be_o`=0x1.
- Assert `rst_ni` low with 3 SENT entries, release, then send ack TID 0 → `empty_o`=1, no pointer movement, `mem_valid_o`=0.
